// File: rtl/sersub_pkg.sv
// sersub_pkg: shared state encoding and default width for the bit-serial subtractor
package sersub_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sersub_state_t;
  localparam int SERSUB_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: combinational 1-bit borrow cell, d = ai - bi - bin, bout = borrow out
//   ai, bi : operand bits
//   bin    : borrow in
//   d      : difference bit
//   bout   : borrow out
module full_subtractor_cell (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = ai ^ bi ^ bin;
  assign bout = (~ai & bi) | (~(ai ^ bi) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first, one bit per clock under start/done handshake
//   clk, rst      : clock, asynchronous active-high reset
//   start         : request, sampled only in IDLE; a/b captured on acceptance
//   busy          : high while bits are being processed
//   done          : one-cycle pulse when diff/borrow/zero (and ovf) are updated
//   diff          : A - B mod 2^WIDTH, held until the next completion
//   borrow        : 1 iff A < B unsigned
//   zero          : diff == 0
//   ovf           : signed overflow, present only when SERSUB_OVF_EN is defined
module serial_subtractor
  import sersub_pkg::*;
#(
  parameter int WIDTH = SERSUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  sersub_state_t    state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d, borrow_q, borrow_d, zero_q, zero_d;
  logic             d, bo, last;
  full_subtractor_cell u_cell (
    .ai  (a_q[0]),
    .bi  (b_q[0]),
    .bin (bor_q),
    .d   (d),
    .bout(bo)
  );
  assign last = cnt_q == CW'(WIDTH - 1);
`ifdef SERSUB_OVF_EN
  logic am_q, am_d, bm_q, bm_d, ovf_q, ovf_d;
`endif
  // a_q doubles as the result register: each difference bit enters at the MSB
  // as the consumed minuend bit leaves at the LSB, so after WIDTH shifts it holds the result.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    bor_d    = bor_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
`ifdef SERSUB_OVF_EN
    am_d     = am_q;
    bm_d     = bm_q;
    ovf_d    = ovf_q;
`endif
    if (state_q == IDLE && start) begin
      state_d = SHIFT;
      a_d     = a;
      b_d     = b;
      bor_d   = 1'b0;
      cnt_d   = '0;
`ifdef SERSUB_OVF_EN
      am_d    = a[WIDTH-1];
      bm_d    = b[WIDTH-1];
`endif
    end else if (state_q == SHIFT) begin
      a_d   = {d, a_q[WIDTH-1:1]};
      b_d   = b_q >> 1;
      bor_d = bo;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d  = DONE;
        diff_d   = a_d;
        borrow_d = bo;
        zero_d   = a_d == '0;
`ifdef SERSUB_OVF_EN
        ovf_d    = (am_q != bm_q) && (d != am_q);
`endif
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      bor_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      bor_q    <= bor_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end
`ifdef SERSUB_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      am_q  <= 1'b0;
      bm_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      am_q  <= am_d;
      bm_q  <= bm_d;
      ovf_q <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`endif
  assign busy   = state_q == SHIFT;
  assign done   = state_q == DONE;
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench with an arithmetic reference model
module tb_serial_subtractor;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow, zero;
  logic [W-1:0] diff;
`ifdef SERSUB_OVF_EN
  logic         ovf;
`endif
  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borrow(borrow),
`ifdef SERSUB_OVF_EN
    .zero  (zero),
    .ovf   (ovf)
`else
    .zero  (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: counts remaining bit-cycles and computes results with plain arithmetic.
  int           rem = 0;
  bit           m_idle = 1'b1, m_done = 1'b0;
  logic [W-1:0] e_diff = '0, p_diff = '0;
  bit           e_borrow = 0, e_zero = 0, e_ovf = 0;
  bit           p_borrow = 0, p_zero = 0, p_ovf = 0;
  int           sd;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem = 0; m_idle = 1; m_done = 0;
      e_diff = '0; e_borrow = 0; e_zero = 0; e_ovf = 0;
    end else if (m_done) begin
      m_done = 0; m_idle = 1;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        m_done = 1; e_diff = p_diff; e_borrow = p_borrow; e_zero = p_zero; e_ovf = p_ovf;
      end
    end else if (m_idle && start) begin
      rem = W; m_idle = 0;
      p_diff = a - b;
      p_borrow = a < b;
      p_zero = a == b;
      sd = int'($signed(a)) - int'($signed(b));
      p_ovf = sd > 127 || sd < -128;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, rem > 0);
    chk("done", done, m_done);
    chk("diff", diff, e_diff);
    chk("borrow", borrow, e_borrow);
    chk("zero", zero, e_zero);
`ifdef SERSUB_OVF_EN
    chk("ovf", ovf, e_ovf);
`endif
  end

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W-1:0] xd,
                        input bit xb, input bit xz, input bit xo, input string nm);
    int lat;
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy"}, busy, 1);
    wait_done(lat);
    chk({nm, "_latency"}, lat - 1, W);
    chk({nm, "_diff"}, diff, xd);
    chk({nm, "_borrow"}, borrow, xb);
    chk({nm, "_zero"}, zero, xz);
`ifdef SERSUB_OVF_EN
    chk({nm, "_ovf"}, ovf, xo);
`else
    if (xo) chk({nm, "_ovf_unused"}, 0, 0);
`endif
    @(negedge clk);
  endtask

  initial begin
    int lat, pulses;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    rst = 1'b0;
    run_op(8'h25, 8'h13, 8'h12, 0, 0, 0, "t1");
    run_op(8'h05, 8'h07, 8'hFE, 1, 0, 0, "t2");
    run_op(8'h00, 8'h00, 8'h00, 0, 1, 0, "t3");
    run_op(8'h80, 8'h01, 8'h7F, 0, 0, 1, "t4a");
    run_op(8'h7F, 8'hFF, 8'h80, 1, 0, 1, "t4b");
    run_op(8'h00, 8'hFF, 8'h01, 1, 0, 0, "edge_lo");
    run_op(8'hFF, 8'h00, 8'hFF, 0, 0, 0, "edge_hi");
    // start held high with operands changing after acceptance
    @(negedge clk);
    a = 8'h30; b = 8'h10; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      lat++;
    end while (!done && lat < 20);
    chk("t5_diff", diff, 8'h20);
    a = 8'h09; b = 8'h04;
    @(negedge clk);
    chk("t5_idle_gap", busy, 0);
    @(negedge clk);
    start = 1'b0;
    chk("t5_reaccept", busy, 1);
    wait_done(lat);
    chk("t5_second_diff", diff, 8'h05);
    @(negedge clk);
    // reset in the middle of SHIFT
    @(negedge clk);
    a = 8'hAA; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_diff", diff, 0);
    chk("t6_done", done, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("t6_no_done", pulses, 0);
    run_op(8'h25, 8'h13, 8'h12, 0, 0, 0, "t6_after");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
